// File: rtl/fcvtws_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fcvtws_unit                                               |
// | Purpose  : binary32 -> signed int32 conversion, round to nearest     |
// |            with ties away from zero, saturating, with an             |
// |            invalid/overflow flag. Combinational core, one output     |
// |            register stage.                                           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fcvtws_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  output logic [31:0] y,
  output logic        exception
);

  localparam logic [31:0] c_INT_MAX   = 32'h7FFF_FFFF;
  localparam logic [31:0] c_INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] c_NEG_2P31  = 32'hCF00_0000;

  logic        w_s;
  logic [7:0]  w_e;
  logic [22:0] w_f;
  logic [31:0] w_m32;
  logic [7:0]  w_lsh;
  logic [7:0]  w_rsh_m1;
  logic [31:0] w_shl;
  logic [31:0] w_pre;
  logic [31:0] w_mag;
  logic [31:0] w_y;
  logic        w_exc;
  logic [31:0] r_y;
  logic        r_exc;

  assign w_s   = x[31];
  assign w_e   = x[30:23];
  assign w_f   = x[22:0];

  // Significand with the hidden one; subnormals never reach the shifters
  // because their exponent falls in the "magnitude 0" band.
  assign w_m32 = {8'd0, 1'b1, w_f};

  // Left shift for integer-valued operands (e in 150..157, shift 0..7).
  assign w_lsh = w_e - 8'd150;
  assign w_shl = w_m32 << w_lsh;

  // Right shift by one less than needed so the 0.5 bit lands at bit 0;
  // e in 126..149 gives a pre-shift of 23..0.
  assign w_rsh_m1 = 8'd149 - w_e;
  assign w_pre    = w_m32 >> w_rsh_m1;

  // Unsigned magnitude, valid for e <= 157.
  always_comb begin
    w_mag = 32'd0;
    if (w_e < 8'd126) begin
      w_mag = 32'd0;
    end else if (w_e >= 8'd150) begin
      w_mag = w_shl;
    end else begin
      w_mag = (w_pre >> 1) + {31'd0, w_pre[0]};
    end
  end

  // Sign application, saturation and exception selection.
  always_comb begin
    w_y   = 32'd0;
    w_exc = 1'b0;
    if (w_e == 8'hFF) begin
      // NaN of either sign saturates positive; only -inf goes negative.
      w_exc = 1'b1;
      w_y   = (w_s && (w_f == 23'd0)) ? c_INT_MIN : c_INT_MAX;
    end else if (w_e >= 8'd158) begin
      if (x == c_NEG_2P31) begin
        // -2^31 is exactly representable.
        w_y   = c_INT_MIN;
        w_exc = 1'b0;
      end else begin
        w_exc = 1'b1;
        w_y   = w_s ? c_INT_MIN : c_INT_MAX;
      end
    end else begin
      w_y = w_s ? ((~w_mag) + 32'd1) : w_mag;
    end
  end

  // Output register stage; reset wins over the sampled operand.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_y   <= 32'd0;
      r_exc <= 1'b0;
    end else begin
      r_y   <= w_y;
      r_exc <= w_exc;
    end
  end

  assign y         = r_y;
  assign exception = r_exc;

endmodule
`default_nettype wire

// File: tb/tb_fcvtws_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fcvtws_unit                                            |
// | Purpose  : self-checking bench for fcvtws_unit: directed vector      |
// |            table, reset sequences and an exponent/sign sweep         |
// |            against a reference conversion model.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_fcvtws_unit;

  logic        clk;
  logic        rstn;
  logic [31:0] x;
  logic [31:0] y;
  logic        exception;

  int n_vec;
  int n_fail;

  typedef struct {
    logic [31:0] xi;
    logic [31:0] ey;
    logic        eexc;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  fcvtws_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .x         (x),
    .y         (y),
    .exception (exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: floor(v + 0.5) computed as floor((floor(2v) + 1) / 2) on
  // 64-bit integers, then range-checked against int32 limits.
  function automatic void ref_conv(input logic [31:0] xi,
                                   output logic [31:0] ry,
                                   output logic rexc);
    logic            s;
    int unsigned     e;
    longint unsigned m, q, mag;
    s = xi[31];
    e = int'(xi[30:23]);
    if (e == 255) begin
      rexc = 1'b1;
      ry   = (s && xi[22:0] == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return;
    end
    m = (e == 0) ? longint'(xi[22:0]) : longint'({1'b1, xi[22:0]});
    if (e >= 190) begin
      mag = 64'hFFFF_FFFF_FFFF;
    end else if (e >= 150) begin
      mag = m << (e - 150);
    end else begin
      q   = (m << 1) >> (150 - e);
      mag = (q + 1) >> 1;
    end
    if (!s && mag > 64'h7FFF_FFFF) begin
      rexc = 1'b1;
      ry   = 32'h7FFF_FFFF;
    end else if (s && mag > 64'h8000_0000) begin
      rexc = 1'b1;
      ry   = 32'h8000_0000;
    end else begin
      rexc = 1'b0;
      ry   = s ? (32'd0 - mag[31:0]) : mag[31:0];
    end
  endfunction

  // One cycle: drive on the falling edge, check #1 after the rising edge.
  task automatic step(input logic rst_v, input logic [31:0] xi,
                      input logic [31:0] ey, input logic eexc,
                      input string name);
    @(negedge clk);
    rstn = rst_v;
    x    = xi;
    @(posedge clk);
    #1;
    n_vec++;
    if (y !== ey || exception !== eexc) begin
      n_fail++;
      $display("FAIL %s x=%h got y=%h exc=%b expected y=%h exc=%b",
               name, xi, y, exception, ey, eexc);
    end
  endtask

  initial begin
    logic [31:0] fr [8];
    logic [31:0] xv, ry;
    logic        rexc;

    n_vec  = 0;
    n_fail = 0;

    vecs[0]  = '{32'h3F00_0000, 32'h0000_0001, 1'b0};
    vecs[1]  = '{32'h4020_0000, 32'h0000_0003, 1'b0};
    vecs[2]  = '{32'hC020_0000, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{32'h3FC0_0000, 32'h0000_0002, 1'b0};
    vecs[4]  = '{32'h3EFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[7]  = '{32'h3F7F_FFFF, 32'h0000_0001, 1'b0};
    vecs[8]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0};
    vecs[9]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0};
    vecs[10] = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[11] = '{32'hCF00_0001, 32'h8000_0000, 1'b1};
    vecs[12] = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[13] = '{32'hFF80_0000, 32'h8000_0000, 1'b1};
    vecs[14] = '{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[15] = '{32'hFFC0_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[16] = '{32'h3F80_0000, 32'h0000_0001, 1'b0};
    vecs[17] = '{32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0};
    vecs[18] = '{32'h4B00_0000, 32'h0080_0000, 1'b0};
    vecs[19] = '{32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0};
    vecs[20] = '{32'h4AFF_FFFF, 32'h0080_0000, 1'b0};

    // Reset holds outputs at zero regardless of x, then first edge loads.
    rstn = 1'b0;
    x    = 32'h4020_0000;
    step(1'b0, 32'h4020_0000, 32'd0, 1'b0, "reset_hold");
    step(1'b0, 32'h4020_0000, 32'd0, 1'b0, "reset_hold2");
    step(1'b1, 32'h4020_0000, 32'd3, 1'b0, "reset_release");

    // Mid-stream reset must clear a loaded result and a raised flag.
    step(1'b1, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, "pre_reset_inf");
    step(1'b0, 32'hC020_0000, 32'd0, 1'b0, "midstream_reset");
    step(1'b1, 32'hC020_0000, 32'hFFFF_FFFD, 1'b0, "post_reset");

    // Directed table, applied back to back.
    for (int i = 0; i < NVEC; i++) begin
      step(1'b1, vecs[i].xi, vecs[i].ey, vecs[i].eexc, $sformatf("vec%0d", i));
    end

    // Sweep every exponent, both signs, a spread of fractions.
    fr[0] = 32'h0;      fr[1] = 32'h1;      fr[2] = 32'h2;
    fr[3] = 32'h700000; fr[4] = 32'h400000; fr[5] = 32'h5FFFFF;
    fr[6] = 32'h7FFFFF; fr[7] = 32'h0;
    for (int e = 0; e < 256; e++) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 8; k++) begin
          if (k == 7) fr[7] = $urandom & 32'h7FFFFF;
          xv = {s[0], e[7:0], fr[k][22:0]};
          ref_conv(xv, ry, rexc);
          step(1'b1, xv, ry, rexc, "sweep");
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
